cmp_minmax_seq: RTL
===================

// Module: cmp_minmax_seq
// PURPOSE
//  Burst min/max scanner built around one shared four_bc comparator instance.
//  - Accepts N_SAMPLES 4-bit samples per burst over a valid/ready handshake.
//  - Time-shares the comparator: one pass against running max, one against running min.
//  - Reports burst max, min and an all-equal flag to the downstream sort/threshold logic.
// PARAMETERS
//  N_SAMPLES  8  samples per burst; legal range 2..15
//  CNT_W      4  sample counter width; must satisfy 2**CNT_W > N_SAMPLES
// PORTS
//  clk        in   1  single clock; all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  begin a burst; sampled only in IDLE
//  in_valid   in   1  sample valid
//  in_data    in   4  sample value, unsigned
//  in_ready   out  1  block can take a sample this cycle
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-cycle pulse when results update
//  max_out    out  4  maximum of last completed burst
//  min_out    out  4  minimum of last completed burst
//  eq_all     out  1  all samples of last completed burst were equal
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, busy, done, max_out, min_out, eq_all, counter and working regs all 0.
//  Comparator mapping: a=sample reg, b=running max or min.
//   - k means a>b, l means a==b, m means a<b.
//  Handshake: a sample transfers when in_valid & in_ready on a rising edge.
//   - in_data is ignored when in_ready=0; the source holds it.
//  FSM:
//   IDLE:    in_ready=0. start=1 -> FIRST. start while not IDLE is ignored.
//   FIRST:   in_ready=1. On transfer: run_max=run_min=in_data, eq=1, cnt=1 -> WAIT.
//   WAIT:    in_ready=1. On transfer: s_reg=in_data -> CMP_MAX.
//   CMP_MAX: a=s_reg, b=run_max. If k: run_max=s_reg. If !l: eq=0. -> CMP_MIN.
//   CMP_MIN: a=s_reg, b=run_min. If m: run_min=s_reg. cnt=cnt+1.
//            Go to DONE if cnt+1==N_SAMPLES, otherwise to WAIT.
//   DONE:    done=1 for one cycle. max_out=run_max, min_out=run_min, eq_all=eq
//            (registered, visible from the next cycle). -> IDLE. A start in this cycle is ignored.
//  Latency:
//   - A sample accepted in WAIT at cycle T gives CMP_MAX T+1, CMP_MIN T+2.
//   - The next possible accept is T+3.
//   - For the last sample, done is high in cycle T+3.
//   - Peak throughput is 1 sample per 3 cycles after the first.
//  Ties: equal values never replace run_max/run_min, so the earliest occurrence wins.
//  Results: max_out/min_out/eq_all hold until the next DONE or reset; they are not cleared by start.
//  Reset mid-burst: abort to IDLE and clear all outputs; done is not pulsed.
//  Counter: never wraps. N_SAMPLES ends the burst before overflow.
// CONFIGURATION
//  Macro MINMAX_INDEX_EN:
//   - Defined: adds ports max_idx out CNT_W and min_idx out CNT_W, both 0-based sample indices.
//   - Indices are tracked with run_max/run_min (FIRST sets both to 0; they update on the same k/m
//     conditions) and registered at DONE.
//   - Reset value of both is 0. Ties keep the earliest index.
//   - Not defined: no index ports or index registers; all other behaviour is identical.
// TESTING  (N_SAMPLES=4, MINMAX_INDEX_EN defined unless stated)
//  1. start; samples 12,10,13,11 with in_valid held high
//     -> max_out=13, min_out=10, eq_all=0, max_idx=2, min_idx=1; done exactly 3 cycles after 4th accept.
//  2. samples 11,11,11,11 -> max_out=min_out=11, eq_all=1, max_idx=min_idx=0.
//  3. Ties: samples 5,9,9,5 -> max_out=9, max_idx=1, min_out=5, min_idx=0.
//  4. Handshake: in_valid toggled 1-0-0-1 and start pulsed while busy
//     -> no sample taken while in_ready=0; second start ignored; results match the accepted samples.
//  5. Reset mid-burst: rst after the 2nd sample
//     -> all outputs 0 next cycle, no done; a new burst 0,15,7,3 gives max_out=15, min_out=0.
//  6. MINMAX_INDEX_EN undefined: repeat test 1 -> same max/min/eq/done timing, no index ports.

Source files
------------

// File: rtl/cmp_minmax_seq.sv
// cmp_minmax_seq: burst min/max scanner sharing one four_bc comparator between max and min passes
// Optional MINMAX_INDEX_EN adds max_idx/min_idx outputs with 0-based sample indices.
module four_bc (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       k,
    output logic       l,
    output logic       m
);
    assign k = a > b;
    assign l = a == b;
    assign m = a < b;
endmodule

module cmp_minmax_seq #(
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [3:0]       max_out,
    output logic [3:0]       min_out,
    output logic             eq_all
`ifdef MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] min_idx
`endif
);
    typedef enum logic [2:0] {IDLE, FIRST, WAIT, CMP_MAX, CMP_MIN, DONE} state_t;
    state_t           state;
    logic [3:0]       s_reg, run_max, run_min, cmp_b;
    logic [CNT_W-1:0] cnt;
    logic             eq, k, l, m, xfer;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0] run_max_idx, run_min_idx;
`endif
    assign xfer  = in_valid & in_ready;
    assign cmp_b = state == CMP_MIN ? run_min : run_max;
    four_bc u_cmp (.a(s_reg), .b(cmp_b), .k(k), .l(l), .m(m));
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            max_out  <= '0;
            min_out  <= '0;
            eq_all   <= 1'b0;
            s_reg    <= '0;
            run_max  <= '0;
            run_min  <= '0;
            cnt      <= '0;
            eq       <= 1'b0;
`ifdef MINMAX_INDEX_EN
            run_max_idx <= '0;
            run_min_idx <= '0;
            max_idx     <= '0;
            min_idx     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= FIRST;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                FIRST: if (xfer) begin
                    run_max <= in_data;
                    run_min <= in_data;
                    eq      <= 1'b1;
                    cnt     <= CNT_W'(1);
`ifdef MINMAX_INDEX_EN
                    run_max_idx <= '0;
                    run_min_idx <= '0;
`endif
                    state   <= WAIT;
                end
                WAIT: if (xfer) begin
                    s_reg    <= in_data;
                    in_ready <= 1'b0;
                    state    <= CMP_MAX;
                end
                CMP_MAX: begin
                    if (k) run_max <= s_reg;
`ifdef MINMAX_INDEX_EN
                    if (k) run_max_idx <= cnt;
`endif
                    if (!l) eq <= 1'b0;
                    state <= CMP_MIN;
                end
                CMP_MIN: begin
                    if (m) run_min <= s_reg;
`ifdef MINMAX_INDEX_EN
                    if (m) run_min_idx <= cnt;
`endif
                    cnt <= cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == CNT_W'(N_SAMPLES)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    max_out <= run_max;
                    min_out <= run_min;
                    eq_all  <= eq;
`ifdef MINMAX_INDEX_EN
                    max_idx <= run_max_idx;
                    min_idx <= run_min_idx;
`endif
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
